// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters.
// Issue is credit-limited so every returning product always has a response FIFO slot.
module mul_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATAWIDTH    = 4,
    parameter int MULT_LATENCY = 3,
    parameter int RSP_DEPTH    = 4,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0] req_b,
    output logic                         mul_i_valid,
    output logic [DATAWIDTH-1:0]         mul_a,
    output logic [DATAWIDTH-1:0]         mul_b,
    input  logic                         mul_o_valid,
    input  logic [2*DATAWIDTH-1:0]       mul_z,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [2*DATAWIDTH-1:0]       rsp_z,
    output logic                         err
);

    localparam int ZW    = 2 * DATAWIDTH;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    // An op is in flight for MULT_LATENCY+1 cycles, so fewer can ever be outstanding in the pipe.
    localparam int MAX_INFLIGHT = (RSP_DEPTH < MULT_LATENCY + 1) ? RSP_DEPTH : MULT_LATENCY + 1;
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 mul_i_valid_q, mul_i_valid_d;
    logic [DATAWIDTH-1:0] mul_a_q, mul_a_d;
    logic [DATAWIDTH-1:0] mul_b_q, mul_b_d;
    logic [INF_W-1:0]     inflight_q, inflight_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [ID_W-1:0]      tag_mem_q [RSP_DEPTH];
    logic [ID_W-1:0]      tag_mem_d [RSP_DEPTH];
    logic [PTR_W-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [ID_W-1:0]      rsp_id_mem_q [RSP_DEPTH];
    logic [ID_W-1:0]      rsp_id_mem_d [RSP_DEPTH];
    logic [ZW-1:0]        rsp_z_mem_q [RSP_DEPTH];
    logic [ZW-1:0]        rsp_z_mem_d [RSP_DEPTH];
    logic [PTR_W-1:0]     rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic                 err_q, err_d;

    logic [DATAWIDTH-1:0] a_arr [NUM_REQ];
    logic [DATAWIDTH-1:0] b_arr [NUM_REQ];
    logic [SUM_W-1:0]     outstanding;
    logic                 can_issue, grant_vld, accept, ret_ok, ret_bad, rsp_pop;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W:0]        scan;
    logic [NUM_REQ-1:0]   ready_vec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*DATAWIDTH +: DATAWIDTH];
            b_arr[i] = req_b[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    // Credit check and round-robin search starting at rr_ptr.
    always_comb begin
        outstanding = SUM_W'(inflight_q) + SUM_W'(fifo_cnt_q);
        can_issue   = outstanding < SUM_W'(RSP_DEPTH);
        grant_vld   = 1'b0;
        grant_id    = '0;
        scan        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[scan[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan[ID_W-1:0];
            end
        end
        ready_vec = '0;
        if (can_issue && grant_vld) begin
            ready_vec[grant_id] = 1'b1;
        end
    end

    always_comb begin
        accept  = can_issue && grant_vld;
        ret_ok  = mul_o_valid && (inflight_q != '0);
        ret_bad = mul_o_valid && (inflight_q == '0);
        rsp_pop = (fifo_cnt_q != '0) && rsp_ready;

        rr_ptr_d      = rr_ptr_q;
        mul_i_valid_d = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        tag_mem_d     = tag_mem_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        rsp_id_mem_d  = rsp_id_mem_q;
        rsp_z_mem_d   = rsp_z_mem_q;
        rsp_wr_d      = rsp_wr_q;
        rsp_rd_d      = rsp_rd_q;
        inflight_d    = inflight_q;
        fifo_cnt_d    = fifo_cnt_q;
        err_d         = err_q | ret_bad;

        if (accept) begin
            rr_ptr_d            = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            mul_i_valid_d       = 1'b1;
            mul_a_d             = a_arr[grant_id];
            mul_b_d             = b_arr[grant_id];
            tag_mem_d[tag_wr_q] = grant_id;
            tag_wr_d            = ptr_inc(tag_wr_q);
        end

        // The multiplier is in-order, so the tag FIFO head always belongs to this result.
        if (ret_ok) begin
            tag_rd_d               = ptr_inc(tag_rd_q);
            rsp_id_mem_d[rsp_wr_q] = tag_mem_q[tag_rd_q];
            rsp_z_mem_d[rsp_wr_q]  = mul_z;
            rsp_wr_d               = ptr_inc(rsp_wr_q);
        end

        if (rsp_pop) begin
            rsp_rd_d = ptr_inc(rsp_rd_q);
        end

        case ({accept, ret_ok})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        case ({ret_ok, rsp_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            mul_i_valid_q <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            inflight_q    <= '0;
            fifo_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            rsp_wr_q      <= '0;
            rsp_rd_q      <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                tag_mem_q[i]    <= '0;
                rsp_id_mem_q[i] <= '0;
                rsp_z_mem_q[i]  <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            mul_i_valid_q <= mul_i_valid_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            inflight_q    <= inflight_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_rd_q      <= rsp_rd_d;
            err_q         <= err_d;
            tag_mem_q     <= tag_mem_d;
            rsp_id_mem_q  <= rsp_id_mem_d;
            rsp_z_mem_q   <= rsp_z_mem_d;
        end
    end

    assign req_ready   = ready_vec;
    assign mul_i_valid = mul_i_valid_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_valid   = (fifo_cnt_q != '0);
    assign rsp_id      = rsp_id_mem_q[rsp_rd_q];
    assign rsp_z       = rsp_z_mem_q[rsp_rd_q];
    assign err         = err_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: behavioural multiplier pipe plus a queue-based reference
// model of issue order, credits, response timing and the sticky error flag.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 4;
    localparam int LAT     = 3;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*DW-1:0]   req_a;
    logic [NUM_REQ*DW-1:0]   req_b;
    logic                    mul_i_valid;
    logic [DW-1:0]           mul_a;
    logic [DW-1:0]           mul_b;
    logic                    mul_o_valid;
    logic [2*DW-1:0]         mul_z;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [2*DW-1:0]         rsp_z;
    logic                    err;

    logic                    inj_valid;
    logic [2*DW-1:0]         inj_z;
    logic [LAT-1:0]          pv;
    logic [2*DW-1:0]         pz [LAT];

    mul_share_arbiter #(
        .NUM_REQ(NUM_REQ), .DATAWIDTH(DW), .MULT_LATENCY(LAT), .RSP_DEPTH(DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_i_valid(mul_i_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_o_valid(mul_o_valid), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
        .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: LAT-cycle pipe, no backpressure; inj_valid forces a stray result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int k = 0; k < LAT; k++) pz[k] <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], mul_i_valid};
            pz[0] <= {4'b0, mul_a} * {4'b0, mul_b};
            for (int k = 1; k < LAT; k++) pz[k] <= pz[k-1];
        end
    end
    assign mul_o_valid = pv[LAT-1] | inj_valid;
    assign mul_z       = inj_valid ? inj_z : pz[LAT-1];

    typedef struct {
        int id;
        int z;
        int ready_cyc;
    } op_t;

    op_t           exp_q[$];
    int            rr;
    int            cyc;
    bit            m_err;
    bit            last_acc;
    int            last_a, last_b;
    bit            pend [NUM_REQ];
    logic [DW-1:0] pa [NUM_REQ];
    logic [DW-1:0] pb [NUM_REQ];
    bit            drv_rsp_ready;
    bit            drv_inj;
    int            n_checks;
    int            n_errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic new_req(input int i, input int a, input int b);
        pend[i] = 1'b1;
        pa[i]   = DW'(a);
        pb[i]   = DW'(b);
    endtask

    // One clock: drive, compare against the model, advance the model, step to next negedge.
    task automatic run_cycle();
        int               g;
        int               in_flight;
        bit               exp_rv;
        logic [NUM_REQ-1:0] exp_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]         = pend[i];
            req_a[i*DW +: DW]    = pa[i];
            req_b[i*DW +: DW]    = pb[i];
        end
        rsp_ready = drv_rsp_ready;
        inj_valid = drv_inj;
        inj_z     = 8'($urandom);
        #1;
        g = -1;
        if (exp_q.size() < DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (rr + k) % NUM_REQ;
                if (g < 0 && pend[i]) g = i;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_ready);
        exp_rv = (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
        check_eq("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check_eq("rsp_id", rsp_id, exp_q[0].id);
            check_eq("rsp_z", rsp_z, exp_q[0].z);
        end
        check_eq("mul_i_valid", mul_i_valid, last_acc);
        check_eq("mul_a", mul_a, last_a);
        check_eq("mul_b", mul_b, last_b);
        check_eq("err", err, m_err);

        in_flight = 0;
        foreach (exp_q[j]) if (exp_q[j].ready_cyc > cyc) in_flight++;
        if (drv_inj && in_flight == 0) m_err = 1'b1;
        if (exp_rv && drv_rsp_ready) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back('{g, int'(pa[g]) * int'(pb[g]), cyc + 2 + LAT});
            pend[g]  = 1'b0;
            rr       = (g + 1) % NUM_REQ;
            last_acc = 1'b1;
            last_a   = int'(pa[g]);
            last_b   = int'(pb[g]);
        end else begin
            last_acc = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_n(input int n);
        for (int c = 0; c < n; c++) run_cycle();
    endtask

    task automatic do_reset();
        req_valid = '0;
        inj_valid = 1'b0;
        drv_inj   = 1'b0;
        rst       = 1'b1;
        #2;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_mul_i_valid", mul_i_valid, 0);
        exp_q.delete();
        rr       = 0;
        m_err    = 1'b0;
        last_acc = 1'b0;
        last_a   = 0;
        last_b   = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; rr = 0; m_err = 0;
        last_acc = 0; last_a = 0; last_b = 0;
        drv_rsp_ready = 0; drv_inj = 0;
        for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; pa[i] = '0; pb[i] = '0; end
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0; inj_valid = 1'b0; inj_z = '0;
        #12;
        check_eq("reset_req_ready", req_ready, 0);
        check_eq("reset_mul_i_valid", mul_i_valid, 0);
        check_eq("reset_mul_a", mul_a, 0);
        check_eq("reset_mul_b", mul_b, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_id", rsp_id, 0);
        check_eq("reset_rsp_z", rsp_z, 0);
        check_eq("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single op from requester 2: 13*11 = 0x8F returned 5 cycles after accept.
        drv_rsp_ready = 1;
        new_req(2, 13, 11);
        run_n(8);

        // All requesters streaming with free-running response drain.
        new_req(0, 15, 15);
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NUM_REQ; i++) if (!pend[i]) new_req(i, $urandom_range(15), $urandom_range(15));
            run_cycle();
        end
        run_n(8);

        // Credit exhaustion with responses held, then a single pop.
        drv_rsp_ready = 0;
        for (int c = 0; c < 10; c++) begin
            if (!pend[0]) new_req(0, $urandom_range(15), $urandom_range(15));
            run_cycle();
        end
        drv_rsp_ready = 1;
        run_cycle();
        drv_rsp_ready = 0;
        for (int c = 0; c < 3; c++) begin
            if (!pend[0]) new_req(0, $urandom_range(15), $urandom_range(15));
            run_cycle();
        end
        drv_rsp_ready = 1;
        run_n(12);

        // Pointer at 2 with requesters 1 and 3 pending; requester 0 joins later.
        new_req(1, 3, 5);
        run_cycle();
        new_req(1, 7, 9);
        new_req(3, 12, 4);
        run_n(2);
        new_req(0, 10, 10);
        run_n(8);

        // Stray multiplier result with nothing outstanding.
        run_n(4);
        drv_inj = 1;
        run_cycle();
        drv_inj = 0;
        run_n(4);
        do_reset();
        run_n(2);

        // Reset with three ops in flight and one response queued.
        drv_rsp_ready = 0;
        new_req(0, 6, 7);
        run_n(6);
        new_req(1, 2, 9);
        new_req(2, 11, 13);
        new_req(3, 14, 5);
        run_n(3);
        do_reset();
        drv_rsp_ready = 1;
        new_req(2, 9, 9);
        run_n(8);

        // Randomized traffic: light then heavy response backpressure.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i] && ($urandom_range(2) == 0)) new_req(i, $urandom_range(15), $urandom_range(15));
            drv_rsp_ready = (c < 300) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            run_cycle();
        end
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
        drv_rsp_ready = 1;
        run_n(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
